// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage pipeline stall/flush/bubble control with data-memory wait FSM and timeout.
// Ports: clk_i/rst_i (sync active-high); idex_memread_i, idex_rd_i, ifid_rs1_i, ifid_rs2_i for
// load-use detection; branch_taken_i; dmem_req_i/dmem_ack_i memory handshake; outputs pc_write_o,
// ifid_write_o, ifid_flush_o, noop_o, hold_o, err_o, stall_cnt_o, flush_cnt_o.
// Optional macro HAZARD_PERF_EN enables saturating stall/flush counters; otherwise they read 0.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rd_i,
  input  logic [4:0]       ifid_rs1_i,
  input  logic [4:0]       ifid_rs2_i,
  input  logic             branch_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ack_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             noop_o,
  output logic             hold_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;
  state_t state;
  logic [10:0] wait_cnt;
  logic load_use, mem_stall, holding, lu, br;
  assign load_use = idex_memread_i & (idex_rd_i != 5'd0) &
                    ((idex_rd_i == ifid_rs1_i) | (idex_rd_i == ifid_rs2_i));
  assign mem_stall = dmem_req_i & ~dmem_ack_i;
  // An acked MEM_WAIT cycle is not holding, so it decodes hazards exactly like RUN.
  assign holding = (state == RUN & mem_stall) | (state == MEM_WAIT & ~dmem_ack_i) | (state == ERROR);
  assign lu = ~holding & load_use;
  assign br = ~holding & ~load_use & branch_taken_i;
  assign pc_write_o   = ~rst_i & ~holding & ~lu;
  assign ifid_write_o = ~rst_i & ~holding & ~lu;
  assign ifid_flush_o = rst_i | br;
  assign noop_o       = rst_i | lu;
  assign hold_o       = ~rst_i & holding;
  assign err_o        = ~rst_i & (state == ERROR);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else if (state == RUN && mem_stall) begin
      state    <= MEM_WAIT;
      wait_cnt <= 11'd1;
    end else if (state == MEM_WAIT) begin
      if (dmem_ack_i) begin
        state    <= RUN;
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + 11'd1;
        // Timeout once the count of non-acked hold cycles reaches MEM_TIMEOUT.
        if (wait_cnt + 11'd1 == 11'(MEM_TIMEOUT)) state <= ERROR;
      end
    end
  end
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic stall_inc, flush_inc;
  assign stall_inc = lu | (holding & state != ERROR);
  assign flush_inc = br;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
  assign stall_cnt_o = stall_cnt;
  assign flush_cnt_o = flush_cnt;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl (default build, MEM_TIMEOUT=4).
module tb_hazard_ctrl;
  logic clk_i = 1'b0;
  logic rst_i, idex_memread_i, branch_taken_i, dmem_req_i, dmem_ack_i;
  logic [4:0] idex_rd_i, ifid_rs1_i, ifid_rs2_i;
  logic pc_write_o, ifid_write_o, ifid_flush_o, noop_o, hold_o, err_o;
  logic [31:0] stall_cnt_o, flush_cnt_o;
  int errs = 0;
  int checks = 0;
  always #5 clk_i = ~clk_i;
  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .idex_memread_i(idex_memread_i), .idex_rd_i(idex_rd_i),
    .ifid_rs1_i(ifid_rs1_i), .ifid_rs2_i(ifid_rs2_i), .branch_taken_i(branch_taken_i),
    .dmem_req_i(dmem_req_i), .dmem_ack_i(dmem_ack_i), .pc_write_o(pc_write_o),
    .ifid_write_o(ifid_write_o), .ifid_flush_o(ifid_flush_o), .noop_o(noop_o),
    .hold_o(hold_o), .err_o(err_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );
  // exp bits: {pc_write, ifid_write, ifid_flush, noop, hold, err}
  task automatic cyc(input string tag, input logic r, input logic mr, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic br,
                     input logic req, input logic ack, input logic [5:0] exp);
    logic [5:0] got;
    rst_i = r; idex_memread_i = mr; idex_rd_i = rd; ifid_rs1_i = rs1; ifid_rs2_i = rs2;
    branch_taken_i = br; dmem_req_i = req; dmem_ack_i = ack;
    @(negedge clk_i);
    got = {pc_write_o, ifid_write_o, ifid_flush_o, noop_o, hold_o, err_o};
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
    end
    checks++;
    assert ({stall_cnt_o, flush_cnt_o} === 64'd0) else begin
      errs++;
      $error("FAIL %s_cnt: observed=%0d/%0d expected=0/0", tag, stall_cnt_o, flush_cnt_o);
    end
    @(posedge clk_i);
    #1;
  endtask
  initial begin
    cyc("reset",        1, 0, 0, 0, 0, 0, 0, 0, 6'b001100);
    cyc("idle",         0, 0, 0, 0, 0, 0, 0, 0, 6'b110000);
    cyc("lu_rs1",       0, 1, 5, 5, 0, 0, 0, 0, 6'b000100);
    cyc("lu_release",   0, 0, 5, 5, 0, 0, 0, 0, 6'b110000);
    cyc("x0_rd",        0, 1, 0, 0, 0, 0, 0, 0, 6'b110000);
    cyc("no_match",     0, 1, 7, 3, 4, 0, 0, 0, 6'b110000);
    cyc("lu_rs2",       0, 1, 7, 3, 7, 0, 0, 0, 6'b000100);
    cyc("br_vs_lu",     0, 1, 5, 5, 0, 1, 0, 0, 6'b000100);
    cyc("br_alone",     0, 0, 5, 5, 0, 1, 0, 0, 6'b111000);
    cyc("req_ack_same", 0, 0, 0, 0, 0, 0, 1, 1, 6'b110000);
    cyc("mw1",          0, 0, 0, 0, 0, 0, 1, 0, 6'b000010);
    cyc("mw2",          0, 0, 0, 0, 0, 1, 1, 0, 6'b000010);
    cyc("mw3",          0, 1, 5, 5, 0, 0, 1, 0, 6'b000010);
    cyc("mw_ack",       0, 0, 0, 0, 0, 0, 1, 1, 6'b110000);
    cyc("after_ack",    0, 0, 0, 0, 0, 0, 0, 0, 6'b110000);
    cyc("mw_vs_lu",     0, 1, 5, 5, 0, 0, 1, 0, 6'b000010);
    cyc("mw_ack_lu",    0, 1, 5, 5, 0, 1, 1, 1, 6'b000100);
    cyc("mw_ack_br",    0, 0, 0, 0, 0, 0, 1, 0, 6'b000010);
    cyc("mw_rel_br",    0, 0, 0, 0, 0, 1, 1, 1, 6'b111000);
    cyc("to1",          0, 0, 0, 0, 0, 0, 1, 0, 6'b000010);
    cyc("to2",          0, 0, 0, 0, 0, 0, 1, 0, 6'b000010);
    cyc("to3",          0, 0, 0, 0, 0, 0, 1, 0, 6'b000010);
    cyc("to4",          0, 0, 0, 0, 0, 0, 1, 0, 6'b000010);
    cyc("to_err",       0, 0, 0, 0, 0, 0, 1, 0, 6'b000011);
    cyc("err_late_ack", 0, 1, 5, 5, 0, 1, 1, 1, 6'b000011);
    cyc("err_sticky",   0, 0, 0, 0, 0, 0, 0, 1, 6'b000011);
    cyc("err_reset",    1, 0, 0, 0, 0, 0, 0, 0, 6'b001100);
    cyc("err_cleared",  0, 0, 0, 0, 0, 0, 0, 0, 6'b110000);
    cyc("rmw1",         0, 0, 0, 0, 0, 0, 1, 0, 6'b000010);
    cyc("rmw2_reset",   1, 0, 0, 0, 0, 0, 1, 0, 6'b001100);
    cyc("rmw_after",    0, 0, 0, 0, 0, 0, 0, 0, 6'b110000);
    cyc("rmw_new_req",  0, 0, 0, 0, 0, 0, 1, 0, 6'b000010);
    cyc("rmw_ack",      0, 0, 0, 0, 0, 0, 1, 1, 6'b110000);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
